// File: rtl/riscv_imm_pkg.sv
// ---------------------------------------------------------------------------
// riscv_imm_pkg
//
// Shared definitions for the RISC-V immediate generator pipeline.
//
// Contents:
//   fmt_e        - immediate format code carried alongside each immediate
//   OPC_*        - base opcodes (instr[6:0]) recognised by the decoder
//   SYS_ZIMM_BIT - funct3 bit that selects the CSR-immediate (zimm) forms
// ---------------------------------------------------------------------------
package riscv_imm_pkg;

    // Format code. Encoding is externally visible on the fmt port, so the
    // values are pinned explicitly rather than left to enum auto-numbering.
    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_Z    = 3'd5,
        FMT_NONE = 3'd7
    } fmt_e;

    // Base opcodes, instr[6:0].
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    // In SYSTEM instructions funct3[2] (instr[14]) marks csrrwi/csrrsi/csrrci,
    // whose rs1 field is a 5-bit zero-extended immediate.
    localparam int SYS_ZIMM_BIT = 14;

endpackage : riscv_imm_pkg

// File: rtl/imm_decode.sv
// ---------------------------------------------------------------------------
// imm_decode
//
// Purely combinational immediate extractor. Classifies the instruction by
// opcode, assembles the format-specific immediate and extends it to XLEN.
//
// Parameters:
//   XLEN    - immediate width, 32 or 64
//
// Ports:
//   instr   in   32    raw instruction word
//   imm     out  XLEN  extended immediate (0 when illegal)
//   fmt     out  3     format code (FMT_NONE when illegal)
//   illegal out  1     opcode not decodable for this XLEN
// ---------------------------------------------------------------------------
module imm_decode
    import riscv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    // Sign-extend a 32-bit value to XLEN (identity when XLEN = 32).
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [31:0]     w_imm_i32;
    logic [31:0]     w_imm_s32;
    logic [31:0]     w_imm_b32;
    logic [31:0]     w_imm_u32;
    logic [31:0]     w_imm_j32;
    logic [XLEN-1:0] w_imm_z;

    // Each format is first assembled as a 32-bit two's-complement value and
    // only then widened, so the RV64 path is a single sign extension.
    assign w_imm_i32 = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
    assign w_imm_u32 = {instr[31:12], 12'b0};
    assign w_imm_j32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
    assign w_imm_z   = {{(XLEN-5){1'b0}}, instr[19:15]};

    // NOTE: every output gets a default before the case so that no path
    // leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b1;

        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                imm     = sext32(w_imm_i32);
                fmt     = FMT_I;
                illegal = 1'b0;
            end
            OPC_STORE: begin
                imm     = sext32(w_imm_s32);
                fmt     = FMT_S;
                illegal = 1'b0;
            end
            OPC_BRANCH: begin
                imm     = sext32(w_imm_b32);
                fmt     = FMT_B;
                illegal = 1'b0;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm     = sext32(w_imm_u32);
                fmt     = FMT_U;
                illegal = 1'b0;
            end
            OPC_JAL: begin
                imm     = sext32(w_imm_j32);
                fmt     = FMT_J;
                illegal = 1'b0;
            end
            OPC_SYSTEM: begin
                // ecall/ebreak/csrrw/csrrs/csrrc carry a 12-bit I immediate
                // (the CSR address); the *i forms carry a 5-bit zimm.
                if (instr[SYS_ZIMM_BIT]) begin
                    imm = w_imm_z;
                    fmt = FMT_Z;
                end else begin
                    imm = sext32(w_imm_i32);
                    fmt = FMT_I;
                end
                illegal = 1'b0;
            end
            OPC_OP_IMM_32: begin
                // addiw/slliw/... exist only in RV64.
                if (XLEN == 64) begin
                    imm     = sext32(w_imm_i32);
                    fmt     = FMT_I;
                    illegal = 1'b0;
                end
            end
            default: begin
                imm     = '0;
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
    end

endmodule : imm_decode

// File: rtl/imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// imm_gen_pipe
//
// Valid/ready wrapped immediate generator. The instruction is decoded
// combinationally on the way in and the result is held in a two-entry
// buffer (output register + skid register). in_ready is a flop, so the
// upstream handshake has no combinational path from out_ready.
// A saturating counter tracks accepted illegal instructions.
//
// Parameters:
//   XLEN         - immediate width, 32 or 64
//   CNT_W        - illegal counter width
//
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      asynchronous active-low reset
//   in_valid     in   1      instr is valid
//   in_ready     out  1      block can accept instr this cycle
//   instr        in   32     raw instruction word
//   out_valid    out  1      imm/fmt/illegal are valid
//   out_ready    in   1      consumer accepts output this cycle
//   imm          out  XLEN   extended immediate
//   fmt          out  3      format code (see riscv_imm_pkg::fmt_e)
//   illegal      out  1      opcode not decodable
//   clr_cnt      in   1      synchronous clear of illegal_cnt (has priority)
//   illegal_cnt  out  CNT_W  saturating count of accepted illegal instrs
// ---------------------------------------------------------------------------
module imm_gen_pipe
    import riscv_imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       fmt,
    output logic             illegal,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0};

    // ------------------------------------------------------------------
    // Decode ahead of the buffer
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_dec_imm;
    fmt_e            w_dec_fmt;
    logic            w_dec_illegal;
    entry_t          w_dec;

    imm_decode #(
        .XLEN    (XLEN)
    ) u_imm_decode (
        .instr   (instr),
        .imm     (w_dec_imm),
        .fmt     (w_dec_fmt),
        .illegal (w_dec_illegal)
    );

    assign w_dec = '{imm: w_dec_imm, fmt: w_dec_fmt, illegal: w_dec_illegal};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    entry_t           r_out;
    logic             r_out_valid;
    entry_t           r_skid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_consume;
    entry_t           w_out_nx;
    logic             w_out_valid_nx;
    logic             w_skid_valid_nx;
    logic             w_skid_load;
    logic [CNT_W-1:0] w_cnt_nx;

    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = r_out_valid && out_ready;

    // ------------------------------------------------------------------
    // Buffer next state
    //
    // The output register refills whenever it is empty or being drained:
    // from skid first (older entry), else from the input. If the output
    // register is stalled, an accepted input parks in skid. An accept can
    // never coincide with a full skid because in_ready mirrors skid-empty.
    // ------------------------------------------------------------------
    always_comb begin
        w_out_nx        = r_out;
        w_out_valid_nx  = r_out_valid;
        w_skid_valid_nx = r_skid_valid;
        w_skid_load     = 1'b0;

        if (!r_out_valid || w_consume) begin
            if (r_skid_valid) begin
                w_out_nx        = r_skid;
                w_out_valid_nx  = 1'b1;
                w_skid_valid_nx = 1'b0;
            end else if (w_accept) begin
                w_out_nx       = w_dec;
                w_out_valid_nx = 1'b1;
            end else begin
                w_out_valid_nx = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_valid_nx = 1'b1;
            w_skid_load     = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Illegal counter next state: clear wins over an increment in the
    // same cycle; increments stop at all-ones.
    // ------------------------------------------------------------------
    always_comb begin
        w_cnt_nx = r_cnt;
        if (clr_cnt) begin
            w_cnt_nx = '0;
        end else if (w_accept && w_dec.illegal && (r_cnt != '1)) begin
            w_cnt_nx = r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers
    //
    // in_ready resets low and rises on the first edge after release,
    // since its next value is computed from the (empty) skid state.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out        <= ENTRY_RST;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_out        <= w_out_nx;
            r_out_valid  <= w_out_valid_nx;
            r_skid_valid <= w_skid_valid_nx;
            r_in_ready   <= !w_skid_valid_nx;
            r_cnt        <= w_cnt_nx;
        end
    end

    // NOTE: the skid payload is deliberately not reset; it is only ever
    // read when r_skid_valid is set, and that flag is reset.
    always_ff @(posedge clk) begin
        if (w_skid_load) begin
            r_skid <= w_dec;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign imm         = r_out.imm;
    assign fmt         = r_out.fmt;
    assign illegal     = r_out.illegal;
    assign illegal_cnt = r_cnt;

endmodule : imm_gen_pipe

// File: tb/tb_imm_gen_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Drives one RV32 instance (3-bit counter, so saturation is reachable) and
// one RV64 instance (default 16-bit counter) with identical stimulus.
// A queue-based reference model tracks what the consumer must see; a
// negedge compare process checks both DUTs against it every cycle, and
// directed vectors carry hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_imm_gen_pipe;

    logic        clk       = 1'b0;
    logic        reset     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_cnt   = 1'b0;
    logic [31:0] instr     = 32'h0;

    logic        ir32, ov32, il32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [2:0]  cnt32;

    logic        ir64, ov64, il64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [15:0] cnt64;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(3)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir32),
        .instr(instr), .out_valid(ov32), .out_ready(out_ready), .imm(imm32),
        .fmt(fmt32), .illegal(il32), .clr_cnt(clr_cnt), .illegal_cnt(cnt32)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir64),
        .instr(instr), .out_valid(ov64), .out_ready(out_ready), .imm(imm64),
        .fmt(fmt64), .illegal(il64), .clr_cnt(clr_cnt), .illegal_cnt(cnt64)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Immediate semantics straight from the ISA field layout.
    function automatic void ref_decode(input logic [31:0] ins, input bit rv64,
                                       output logic [63:0] v, output logic [2:0] f,
                                       output logic ill);
        logic signed [11:0] s12;
        logic signed [12:0] s13;
        logic signed [20:0] s21;
        logic signed [31:0] s32;
        logic        [4:0]  z5;
        v = 64'h0; f = 3'd7; ill = 1'b1;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin
                s12 = ins[31:20]; v = 64'(s12); f = 3'd0; ill = 1'b0;
            end
            7'h23: begin
                s12 = {ins[31:25], ins[11:7]}; v = 64'(s12); f = 3'd1; ill = 1'b0;
            end
            7'h63: begin
                s13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                v = 64'(s13); f = 3'd2; ill = 1'b0;
            end
            7'h37, 7'h17: begin
                s32 = {ins[31:12], 12'h000}; v = 64'(s32); f = 3'd3; ill = 1'b0;
            end
            7'h6F: begin
                s21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                v = 64'(s21); f = 3'd4; ill = 1'b0;
            end
            7'h73: begin
                ill = 1'b0;
                if (ins[14]) begin
                    z5 = ins[19:15]; v = 64'(z5); f = 3'd5;
                end else begin
                    s12 = ins[31:20]; v = 64'(s12); f = 3'd0;
                end
            end
            7'h1B: begin
                if (rv64) begin
                    s12 = ins[31:20]; v = 64'(s12); f = 3'd0; ill = 1'b0;
                end
            end
            default: ;
        endcase
        if (!rv64) v = {32'h0, v[31:0]};
    endfunction

    logic [31:0] q[$];       // entries awaiting delivery, oldest first
    bit          m_ready  = 1'b0;
    int          m_cnt32  = 0;
    int          m_cnt64  = 0;
    bit          last_push = 1'b0;

    task automatic model_reset();
        q.delete();
        m_ready = 1'b0;
        m_cnt32 = 0;
        m_cnt64 = 0;
    endtask

    // Advance one clock: evaluate the handshakes on pre-edge inputs,
    // apply them to the model at the edge, then settle for 1 time unit.
    task automatic tick();
        bit          pop, push;
        logic [63:0] v;
        logic [2:0]  f;
        logic        ill32, ill64;
        pop  = (q.size() > 0) && out_ready;
        push = in_valid && m_ready;
        ref_decode(instr, 1'b0, v, f, ill32);
        ref_decode(instr, 1'b1, v, f, ill64);
        @(posedge clk);
        last_push = 1'b0;
        if (reset) begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(instr);
                last_push = 1'b1;
            end
            if (clr_cnt) begin
                m_cnt32 = 0;
                m_cnt64 = 0;
            end else if (push) begin
                if (ill32 && m_cnt32 < 7)     m_cnt32++;
                if (ill64 && m_cnt64 < 65535) m_cnt64++;
            end
            m_ready = (q.size() < 2);
        end
        #1;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [63:0] v32, v64;
        logic [2:0]  f32, f64;
        logic        i32, i64;
        check("out_valid32", 64'(ov32), 64'(q.size() > 0));
        check("out_valid64", 64'(ov64), 64'(q.size() > 0));
        check("in_ready32",  64'(ir32), 64'(m_ready));
        check("in_ready64",  64'(ir64), 64'(m_ready));
        check("cnt32",       64'(cnt32), 64'(m_cnt32));
        check("cnt64",       64'(cnt64), 64'(m_cnt64));
        if (q.size() > 0) begin
            ref_decode(q[0], 1'b0, v32, f32, i32);
            ref_decode(q[0], 1'b1, v64, f64, i64);
            check("imm32", 64'(imm32), v32);
            check("fmt32", 64'(fmt32), 64'(f32));
            check("ill32", 64'(il32),  64'(i32));
            check("imm64", imm64,      v64);
            check("fmt64", 64'(fmt64), 64'(f64));
            check("ill64", 64'(il64),  64'(i64));
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm32;
        logic [2:0]  f32;
        logic [63:0] imm64;
        logic [2:0]  f64;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mv;
        logic [2:0]  mf;
        logic        mi;

        vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd0}; // addi -1
        vecs[1]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd1, 64'hFFFFFFFFFFFFFFFC, 3'd1}; // sw -4
        vecs[2]  = '{32'h340FD0F3, 32'h0000001F, 3'd5, 64'h000000000000001F, 3'd5}; // csrrwi zimm 31
        vecs[3]  = '{32'h800000B7, 32'h80000000, 3'd3, 64'hFFFFFFFF80000000, 3'd3}; // lui
        vecs[4]  = '{32'h0010009B, 32'h00000000, 3'd7, 64'h0000000000000001, 3'd0}; // addiw
        vecs[5]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd4, 64'hFFFFFFFFFFFFFFFC, 3'd4}; // jal -4
        vecs[6]  = '{32'hFE000FE3, 32'hFFFFFFFE, 3'd2, 64'hFFFFFFFFFFFFFFFE, 3'd2}; // beq -2
        vecs[7]  = '{32'h00000073, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0}; // ecall
        vecs[8]  = '{32'h00000000, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7}; // illegal
        vecs[9]  = '{32'h12345037, 32'h12345000, 3'd3, 64'h0000000012345000, 3'd3}; // lui positive
        vecs[10] = '{32'h00008067, 32'h00000000, 3'd0, 64'h0000000000000000, 3'd0}; // ret
        vecs[11] = '{32'h7FF02003, 32'h000007FF, 3'd0, 64'h00000000000007FF, 3'd0}; // lw +2047

        // Pin the model itself against the hand-computed table.
        foreach (vecs[i]) begin
            ref_decode(vecs[i].ins, 1'b0, mv, mf, mi);
            check("model_imm32", mv, {32'h0, vecs[i].imm32});
            check("model_fmt32", 64'(mf), 64'(vecs[i].f32));
            ref_decode(vecs[i].ins, 1'b1, mv, mf, mi);
            check("model_imm64", mv, vecs[i].imm64);
            check("model_fmt64", 64'(mf), 64'(vecs[i].f64));
        end

        // ---- reset state ----
        model_reset();
        tick();
        tick();
        check("rst_ov32",  64'(ov32),  64'd0);
        check("rst_ir32",  64'(ir32),  64'd0);
        check("rst_imm32", 64'(imm32), 64'd0);
        check("rst_fmt32", 64'(fmt32), 64'd7);
        check("rst_ill32", 64'(il32),  64'd0);
        check("rst_cnt32", 64'(cnt32), 64'd0);
        check("rst_ov64",  64'(ov64),  64'd0);
        check("rst_ir64",  64'(ir64),  64'd0);
        check("rst_imm64", imm64,      64'd0);
        check("rst_fmt64", 64'(fmt64), 64'd7);
        check("rst_cnt64", 64'(cnt64), 64'd0);
        reset = 1'b1;
        tick();
        check("rel_ir32", 64'(ir32), 64'd1);
        check("rel_ir64", 64'(ir64), 64'd1);

        // ---- streaming, one transfer per cycle ----
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            instr    = vecs[i].ins;
            in_valid = 1'b1;
            tick();
            check("str_ov32",  64'(ov32),  64'd1);
            check("str_imm32", 64'(imm32), 64'(vecs[i].imm32));
            check("str_fmt32", 64'(fmt32), 64'(vecs[i].f32));
            check("str_ill32", 64'(il32),  64'(vecs[i].f32 == 3'd7));
            check("str_imm64", imm64,      vecs[i].imm64);
            check("str_fmt64", 64'(fmt64), 64'(vecs[i].f64));
            check("str_ill64", 64'(il64),  64'(vecs[i].f64 == 3'd7));
        end
        in_valid = 1'b0;
        tick();
        check("drain_ov32", 64'(ov32), 64'd0);

        // ---- back-pressure: 3 back-to-back inputs ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hFFF00093;
        tick();
        check("bp_ir_after1", 64'(ir32), 64'd1);
        instr = 32'hFE112E23;
        tick();
        check("bp_ir_after2", 64'(ir32), 64'd0);
        instr = 32'h340FD0F3;
        tick();
        tick();
        check("bp_hold_imm32", 64'(imm32), 64'hFFFFFFFF);
        check("bp_hold_fmt32", 64'(fmt32), 64'd0);
        out_ready = 1'b1;
        tick();
        check("bp_second_imm32", 64'(imm32), 64'hFFFFFFFC);
        check("bp_ir_reopen",    64'(ir32),  64'd1);
        begin
            int budget = 10;
            while (!last_push && budget > 0) begin
                tick();
                budget--;
            end
            check("bp_third_accepted", 64'(last_push), 64'd1);
        end
        in_valid = 1'b0;
        check("bp_third_imm32", 64'(imm32), 64'h1F);
        tick();
        check("bp_empty", 64'(ov32), 64'd0);

        // ---- illegal counter ----
        clr_cnt = 1'b1;
        tick();
        clr_cnt  = 1'b0;
        instr    = 32'h00000000;
        in_valid = 1'b1;
        repeat (3) tick();
        check("cnt3_32",  64'(cnt32), 64'd3);
        check("cnt3_64",  64'(cnt64), 64'd3);
        check("cnt_fmt7", 64'(fmt32), 64'd7);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("cnt_clr32", 64'(cnt32), 64'd0);
        check("cnt_clr64", 64'(cnt64), 64'd0);
        repeat (9) tick();
        check("cnt_sat32", 64'(cnt32), 64'd7);
        check("cnt_9_64",  64'(cnt64), 64'd9);
        in_valid = 1'b0;
        tick();

        // ---- reset mid-stream with skid full ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hFFDFF06F;
        tick();
        instr = 32'hFE000FE3;
        tick();
        in_valid = 1'b0;
        check("mid_skid_full", 64'(ir32), 64'd0);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("mid_ov32",  64'(ov32),  64'd0);
        check("mid_ov64",  64'(ov64),  64'd0);
        check("mid_cnt32", 64'(cnt32), 64'd0);
        check("mid_cnt64", 64'(cnt64), 64'd0);
        check("mid_ir32",  64'(ir32),  64'd0);
        check("mid_fmt32", 64'(fmt32), 64'd7);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("post_ir32", 64'(ir32), 64'd1);
        check("post_ir64", 64'(ir64), 64'd1);
        check("post_ov32", 64'(ov32), 64'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("post_ov64", 64'(ov64), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_imm_gen_pipe
